ddr_cmd_encoder: RTL and testbench

- Downstream of the DDR4 initialization sequencer. Converts its one-hot init requests (mrs_rdy/des_rdy/zqcl_rdy plus mode_reg) into registered DDR4 command-bus pin values.
- After config_done, accepts ACT/RD/WR/PRE/REF requests from the scheduler over a valid/ready handshake.
- Enforces the minimum per-bank and bus timing before issuing, and generates CA parity.

---
 rtl/ddr_cmd_encoder_pkg.sv | 54 +++++
 rtl/ddr_cmd_encoder_bank_timer.sv | 28 ++
 rtl/ddr_cmd_encoder.sv | 193 +++++++++++++++++++
 tb/tb_ddr_cmd_encoder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_cmd_encoder_pkg.sv
// Shared command enum, pin encodings and timing defaults for the DDR4
// command-bus encoder and its bank timers.
package ddr_cmd_encoder_pkg;

  typedef enum logic [2:0] {
    NOP = 3'd0,
    ACT = 3'd1,
    RD  = 3'd2,
    WR  = 3'd3,
    PRE = 3'd4,
    REF = 3'd5
  } ddr_cmd_t;

  localparam int MODE_W    = 19;
  localparam int NUM_BANKS = 16;

  // Init-sequence spacing, honoured upstream by the init sequencer.
  localparam int T_MRD    = 8;
  localparam int T_MOD    = 24;
  localparam int T_ZQINIT = 1024;

  localparam int T_RCD = 10;
  localparam int T_RP  = 10;
  localparam int T_CCD = 4;
  localparam int T_RFC = 160;

  // {RAS_n/A16, CAS_n/A15, WE_n/A14} with ACT_n high.
  localparam logic [2:0] RCW_MRS  = 3'b000;
  localparam logic [2:0] RCW_ZQCL = 3'b110;
  localparam logic [2:0] RCW_RD   = 3'b101;
  localparam logic [2:0] RCW_WR   = 3'b100;
  localparam logic [2:0] RCW_PRE  = 3'b010;
  localparam logic [2:0] RCW_REF  = 3'b001;

  typedef struct packed {
    logic        cs_n;
    logic        act_n;
    logic [2:0]  rcw;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic        a17;
    logic [13:0] addr;
    logic        par;
  } ddr_pins_t;

  localparam ddr_pins_t PINS_RST = '{cs_n: 1'b1, act_n: 1'b1, rcw: 3'b111,
                                     bg: 2'b00, ba: 2'b00, a17: 1'b0,
                                     addr: 14'h0, par: 1'b0};

  function automatic logic ca_parity(input ddr_pins_t p);
    return ^{p.act_n, p.rcw, p.bg, p.ba, p.a17, p.addr};
  endfunction

endpackage

// File: rtl/ddr_cmd_encoder_bank_timer.sv
// Per-bank saturating down-counter; zero means the bank may take a
// timing-gated command.
module ddr_bank_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clock_t,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                cnt_d = load_val;
    else if (cnt_q != '0)    cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/ddr_cmd_encoder.sv
// DDR4 command-bus encoder: init-sequencer requests, then timing-gated
// scheduler commands, driven onto registered pins with even CA parity.
module ddr_cmd_encoder
  import ddr_cmd_encoder_pkg::*;
(
  input  logic              clock_t,
  input  logic              reset_n,
  input  logic              mrs_rdy,
  input  logic              des_rdy,
  input  logic              zqcl_rdy,
  input  logic              config_done,
  input  logic [MODE_W-1:0] mode_reg,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_type,
  input  logic [1:0]        cmd_bg,
  input  logic [1:0]        cmd_ba,
  input  logic [16:0]       cmd_row,
  input  logic [9:0]        cmd_col,
  input  logic              cmd_ap,
  output logic              cs_n,
  output logic              act_n,
  output logic              ras_n_a16,
  output logic              cas_n_a15,
  output logic              we_n_a14,
  output logic [1:0]        bg,
  output logic [1:0]        ba,
  output logic              a17,
  output logic [13:0]       addr,
  output logic              par,
  output logic              proto_err
);

  localparam int BT_W  = $clog2((T_RCD > T_RP) ? T_RCD : T_RP);
  localparam int CCD_W = $clog2(T_CCD);
  localparam int RFC_W = $clog2(T_RFC);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_RFC} state_t;

  state_t                 state_q, state_d;
  ddr_pins_t              pins_q, pins_d;
  logic                   err_q, err_d;
  logic [CCD_W-1:0]       ccd_q, ccd_d;
  logic [RFC_W-1:0]       rfc_q, rfc_d;
  logic [NUM_BANKS-1:0]   act_open_q, act_open_d;
  logic [NUM_BANKS-1:0]   bank_load, bank_zero;
  logic [BT_W-1:0]        bank_ld_val;
  logic [3:0]             bank_sel;
  ddr_cmd_t               cmd;
  logic                   cmd_ok, issue;

  assign cmd      = ddr_cmd_t'(cmd_type);
  assign bank_sel = {cmd_bg, cmd_ba};

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    ddr_bank_timer #(.CNT_W(BT_W)) u_timer (
      .clock_t  (clock_t),
      .reset_n  (reset_n),
      .load     (bank_load[i]),
      .load_val (bank_ld_val),
      .zero     (bank_zero[i])
    );
  end

  // A bank whose last command was ACT cannot be re-activated without PRE.
  always_comb begin
    case (cmd)
      ACT:     cmd_ok = bank_zero[bank_sel] && !act_open_q[bank_sel];
      RD, WR:  cmd_ok = bank_zero[bank_sel] && (ccd_q == '0);
      default: cmd_ok = 1'b1;
    endcase
  end

  assign cmd_ready = (state_q == S_RUN) && cmd_ok;
  assign issue     = cmd_ready && cmd_valid;

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    rfc_d       = rfc_q;
    ccd_d       = (ccd_q != '0) ? ccd_q - 1'b1 : ccd_q;
    act_open_d  = act_open_q;
    bank_load   = '0;
    bank_ld_val = BT_W'(T_RP - 1);
    pins_d      = pins_q;
    pins_d.cs_n = 1'b1;
    case (state_q)
      S_INIT: begin
        if ((mrs_rdy & zqcl_rdy) | (mrs_rdy & des_rdy) | (zqcl_rdy & des_rdy)) err_d = 1'b1;
        if (mrs_rdy) begin
          pins_d.cs_n  = 1'b0;
          pins_d.act_n = 1'b1;
          pins_d.rcw   = RCW_MRS;
          pins_d.bg    = mode_reg[18:17];
          pins_d.ba    = mode_reg[16:15];
          pins_d.a17   = mode_reg[14];
          pins_d.addr  = mode_reg[13:0];
        end else if (zqcl_rdy) begin
          pins_d.cs_n  = 1'b0;
          pins_d.act_n = 1'b1;
          pins_d.rcw   = RCW_ZQCL;
          pins_d.bg    = 2'b00;
          pins_d.ba    = 2'b00;
          pins_d.a17   = 1'b0;
          pins_d.addr  = 14'h0400;
        end
        if (config_done) state_d = S_RUN;
      end
      S_RUN: begin
        if (mrs_rdy | zqcl_rdy) err_d = 1'b1;
        if (issue && cmd != NOP) begin
          pins_d.cs_n  = 1'b0;
          pins_d.act_n = 1'b1;
          pins_d.bg    = cmd_bg;
          pins_d.ba    = cmd_ba;
          pins_d.a17   = 1'b0;
          pins_d.addr  = '0;
          case (cmd)
            ACT: begin
              pins_d.act_n         = 1'b0;
              pins_d.rcw           = cmd_row[16:14];
              pins_d.addr          = cmd_row[13:0];
              bank_load[bank_sel]  = 1'b1;
              bank_ld_val          = BT_W'(T_RCD - 1);
              act_open_d[bank_sel] = 1'b1;
            end
            RD, WR: begin
              pins_d.rcw           = (cmd == RD) ? RCW_RD : RCW_WR;
              pins_d.addr          = {3'b000, cmd_ap, cmd_col};
              ccd_d                = CCD_W'(T_CCD - 1);
              bank_load[bank_sel]  = cmd_ap;
              act_open_d[bank_sel] = 1'b0;
            end
            PRE: begin
              pins_d.rcw           = RCW_PRE;
              bank_load[bank_sel]  = 1'b1;
              act_open_d[bank_sel] = 1'b0;
            end
            REF: begin
              pins_d.rcw = RCW_REF;
              pins_d.bg  = 2'b00;
              pins_d.ba  = 2'b00;
              state_d    = S_RFC;
              rfc_d      = RFC_W'(T_RFC - 1);
            end
            default: pins_d.cs_n = 1'b1;
          endcase
        end
        if (!config_done) begin
          state_d = S_INIT;
          err_d   = 1'b1;
        end
      end
      S_RFC: begin
        if (mrs_rdy | zqcl_rdy) err_d = 1'b1;
        if (rfc_q == '0) state_d = S_RUN;
        else             rfc_d   = rfc_q - 1'b1;
      end
      default: state_d = S_INIT;
    endcase
    // DES cycles hold address pins but force parity low.
    pins_d.par = pins_d.cs_n ? 1'b0 : ca_parity(pins_d);
  end

  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_INIT;
      pins_q     <= PINS_RST;
      err_q      <= 1'b0;
      ccd_q      <= '0;
      rfc_q      <= '0;
      act_open_q <= '0;
    end else begin
      state_q    <= state_d;
      pins_q     <= pins_d;
      err_q      <= err_d;
      ccd_q      <= ccd_d;
      rfc_q      <= rfc_d;
      act_open_q <= act_open_d;
    end
  end

  assign cs_n                              = pins_q.cs_n;
  assign act_n                             = pins_q.act_n;
  assign {ras_n_a16, cas_n_a15, we_n_a14}  = pins_q.rcw;
  assign bg                                = pins_q.bg;
  assign ba                                = pins_q.ba;
  assign a17                               = pins_q.a17;
  assign addr                              = pins_q.addr;
  assign par                               = pins_q.par;
  assign proto_err                         = err_q;

endmodule

// File: tb/tb_ddr_cmd_encoder.sv
// Directed + random bench for ddr_cmd_encoder against a timestamp-based model.
module tb_ddr_cmd_encoder;
  import ddr_cmd_encoder_pkg::*;

  logic        clock_t = 1'b0, reset_n = 1'b0;
  logic        mrs_rdy, des_rdy, zqcl_rdy, config_done;
  logic [18:0] mode_reg;
  logic        cmd_valid, cmd_ready, cmd_ap;
  logic [2:0]  cmd_type;
  logic [1:0]  cmd_bg, cmd_ba;
  logic [16:0] cmd_row;
  logic [9:0]  cmd_col;
  logic        cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14, a17, par, proto_err;
  logic [1:0]  bg, ba;
  logic [13:0] addr;

  ddr_cmd_encoder dut (
    .clock_t(clock_t), .reset_n(reset_n), .mrs_rdy(mrs_rdy), .des_rdy(des_rdy),
    .zqcl_rdy(zqcl_rdy), .config_done(config_done), .mode_reg(mode_reg),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_bg(cmd_bg), .cmd_ba(cmd_ba), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .cmd_ap(cmd_ap), .cs_n(cs_n), .act_n(act_n), .ras_n_a16(ras_n_a16),
    .cas_n_a15(cas_n_a15), .we_n_a14(we_n_a14), .bg(bg), .ba(ba), .a17(a17),
    .addr(addr), .par(par), .proto_err(proto_err)
  );

  always #5 clock_t = ~clock_t;

  localparam int M_INIT = 0, M_RUN = 1, M_RFC = 2;

  int tests, fails;
  int now, mstate, ccd_ok_at, rfc_exit;
  int bank_ok_at [16];
  bit bank_open  [16];
  logic        e_cs, e_act, e_a17, e_par, e_err, exp_ready, obs_ready;
  logic [2:0]  e_rcw;
  logic [1:0]  e_bg, e_ba;
  logic [13:0] e_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_pins();
    return 32'({cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14, bg, ba, a17, addr, par});
  endfunction

  function automatic logic [31:0] exp_pins();
    return 32'({e_cs, e_act, e_rcw, e_bg, e_ba, e_a17, e_addr, e_par});
  endfunction

  task automatic model_reset();
    mstate = M_INIT; e_cs = 1'b1; e_act = 1'b1; e_rcw = 3'b111; e_bg = 2'b00;
    e_ba = 2'b00; e_a17 = 1'b0; e_addr = 14'h0; e_par = 1'b0; e_err = 1'b0;
    ccd_ok_at = 0; rfc_exit = 0;
    for (int i = 0; i < 16; i++) begin bank_ok_at[i] = 0; bank_open[i] = 1'b0; end
  endtask

  task automatic drive(input logic a, input logic [2:0] r, input logic [1:0] g,
                       input logic [1:0] k, input logic h, input logic [13:0] ad);
    e_cs = 1'b0; e_act = a; e_rcw = r; e_bg = g; e_ba = k; e_a17 = h; e_addr = ad;
    e_par = ^{e_act, e_rcw, e_bg, e_ba, e_a17, e_addr};
  endtask

  // Predicts cmd_ready for the coming edge and the pin values after it.
  task automatic model_eval();
    int b;
    b = int'({cmd_bg, cmd_ba});
    e_cs = 1'b1; e_par = 1'b0; exp_ready = 1'b0;
    case (mstate)
      M_INIT: begin
        if (int'(mrs_rdy) + int'(zqcl_rdy) + int'(des_rdy) > 1) e_err = 1'b1;
        if (mrs_rdy)       drive(1'b1, 3'b000, mode_reg[18:17], mode_reg[16:15], mode_reg[14], mode_reg[13:0]);
        else if (zqcl_rdy) drive(1'b1, 3'b110, 2'b00, 2'b00, 1'b0, 14'h0400);
        if (config_done) mstate = M_RUN;
      end
      M_RUN: begin
        if (mrs_rdy || zqcl_rdy) e_err = 1'b1;
        if (cmd_type == ACT)                         exp_ready = (now >= bank_ok_at[b]) && !bank_open[b];
        else if (cmd_type == RD || cmd_type == WR)   exp_ready = (now >= bank_ok_at[b]) && (now >= ccd_ok_at);
        else                                         exp_ready = 1'b1;
        if (cmd_valid && exp_ready) begin
          case (cmd_type)
            ACT: begin
              drive(1'b0, cmd_row[16:14], cmd_bg, cmd_ba, 1'b0, cmd_row[13:0]);
              bank_ok_at[b] = now + T_RCD; bank_open[b] = 1'b1;
            end
            RD, WR: begin
              drive(1'b1, (cmd_type == RD) ? 3'b101 : 3'b100, cmd_bg, cmd_ba, 1'b0, {3'b000, cmd_ap, cmd_col});
              ccd_ok_at = now + T_CCD; bank_open[b] = 1'b0;
              if (cmd_ap) bank_ok_at[b] = now + T_RP;
            end
            PRE: begin
              drive(1'b1, 3'b010, cmd_bg, cmd_ba, 1'b0, 14'h0);
              bank_ok_at[b] = now + T_RP; bank_open[b] = 1'b0;
            end
            REF: begin
              drive(1'b1, 3'b001, 2'b00, 2'b00, 1'b0, 14'h0);
              mstate = M_RFC; rfc_exit = now + T_RFC;
            end
            default: ;
          endcase
        end
        if (!config_done) begin mstate = M_INIT; e_err = 1'b1; end
      end
      default: begin
        if (mrs_rdy || zqcl_rdy) e_err = 1'b1;
        if (now >= rfc_exit) mstate = M_RUN;
      end
    endcase
  endtask

  task automatic tick();
    @(negedge clock_t);
    obs_ready = cmd_ready;
    model_eval();
    chk("cmd_ready", 32'(obs_ready), 32'(exp_ready));
    @(posedge clock_t);
    now++;
    #1;
    chk("pins", obs_pins(), exp_pins());
    chk("proto_err", 32'(proto_err), 32'(e_err));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Holds a command valid until the DUT takes it; reports stall count and issue edge.
  task automatic issue(input logic [2:0] t, input logic [3:0] b, input logic [16:0] row,
                       input logic [9:0] col, input logic ap, output int waits, output int at);
    int e;
    cmd_type = t; {cmd_bg, cmd_ba} = b; cmd_row = row; cmd_col = col; cmd_ap = ap;
    cmd_valid = 1'b1; waits = 0; at = -1;
    for (int k = 0; k < 400 && at < 0; k++) begin
      e = now;
      tick();
      if (obs_ready) at = e; else waits++;
    end
    cmd_valid = 1'b0; cmd_type = NOP;
    chk("issue_timeout", (at >= 0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic check_reset(input string tag);
    chk(tag, obs_pins(), 32'({1'b1, 1'b1, 3'b111, 2'b00, 2'b00, 1'b0, 14'h0, 1'b0}));
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_err", 32'(proto_err), 32'd0);
  endtask

  initial begin
    int w, t0, t1, t2, t3, r;
    tests = 0; fails = 0; now = 0;
    mrs_rdy = 0; des_rdy = 0; zqcl_rdy = 0; config_done = 0; mode_reg = '0;
    cmd_valid = 0; cmd_type = NOP; cmd_bg = 0; cmd_ba = 0; cmd_row = 0; cmd_col = 0; cmd_ap = 0;
    model_reset();
    #12;
    check_reset("reset_pins");
    @(posedge clock_t); #1; reset_n = 1'b1;
    idle(1);

    mrs_rdy = 1; mode_reg = 19'h18004; tick(); mrs_rdy = 0;
    chk("mrs_addr", 32'(addr), 32'h0004);
    chk("mrs_rcw", 32'({cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14}), 32'b01000);
    zqcl_rdy = 1; mode_reg = '1; tick(); zqcl_rdy = 0;
    chk("zq_addr", 32'(addr), 32'h0400);
    chk("zq_bgba", 32'({bg, ba, ras_n_a16, cas_n_a15, we_n_a14}), 32'b0000110);
    for (int i = 0; i < 4; i++) begin
      mrs_rdy = 1; mode_reg = 19'($urandom); tick();
    end
    mrs_rdy = 0; des_rdy = 1; tick(); des_rdy = 0;
    chk("init_no_err", 32'(proto_err), 32'd0);

    config_done = 1; tick();
    issue(ACT, 4'd2, 17'($urandom), 10'd0, 1'b0, w, t0);
    idle(12);
    issue(ACT, 4'd5, 17'h1ABCD, 10'd0, 1'b0, w, t0);
    issue(RD, 4'd5, 17'd0, 10'($urandom), 1'b0, w, t1);
    chk("rd_trcd_waits", 32'(w), 32'd9);
    chk("rd_trcd_gap", 32'(t1 - t0), 32'd10);
    idle(4);
    issue(ACT, 4'd6, 17'($urandom), 10'd0, 1'b0, w, t0);
    issue(RD, 4'd2, 17'd0, 10'($urandom), 1'b0, w, t1);
    chk("rd_other_bank", 32'(w), 32'd0);

    issue(WR, 4'd2, 17'd0, 10'($urandom), 1'b0, w, t1);
    issue(WR, 4'd2, 17'd0, 10'($urandom), 1'b0, w, t2);
    issue(WR, 4'd2, 17'd0, 10'($urandom), 1'b0, w, t3);
    chk("wr_tccd_1", 32'(t2 - t1), 32'd4);
    chk("wr_tccd_2", 32'(t3 - t2), 32'd4);
    issue(RD, 4'd2, 17'd0, 10'($urandom), 1'b1, w, t1);
    issue(ACT, 4'd2, 17'($urandom), 10'd0, 1'b0, w, t2);
    chk("ap_trp_gap", 32'(t2 - t1), 32'd10);

    issue(REF, 4'd0, 17'd0, 10'd0, 1'b0, w, t0);
    issue(ACT, 4'd3, 17'($urandom), 10'd0, 1'b0, w, t1);
    chk("rfc_waits", 32'(w), 32'd160);
    chk("rfc_gap", 32'(t1 - t0), 32'd161);

    config_done = 0; tick();
    chk("cfg_drop_err", 32'(proto_err), 32'd1);
    config_done = 1; tick();

    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 25)      cmd_type = ACT;
      else if (r < 45) cmd_type = RD;
      else if (r < 65) cmd_type = WR;
      else if (r < 80) cmd_type = PRE;
      else if (r < 98) cmd_type = NOP;
      else             cmd_type = REF;
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_bg = 2'($urandom_range(0, 1)); cmd_ba = 2'($urandom_range(0, 1));
      cmd_row = 17'($urandom); cmd_col = 10'($urandom); cmd_ap = 1'($urandom);
      mrs_rdy = ($urandom_range(0, 63) == 0);
      tick();
    end
    mrs_rdy = 0; cmd_valid = 0; cmd_type = NOP;

    reset_n = 0; config_done = 0; #1;
    model_reset();
    @(posedge clock_t); #1; reset_n = 1'b1;
    mrs_rdy = 1; zqcl_rdy = 1; mode_reg = 19'($urandom); tick();
    chk("multi_req_err", 32'(proto_err), 32'd1);
    chk("multi_req_mrs", 32'({cs_n, ras_n_a16, cas_n_a15, we_n_a14}), 32'b0000);
    mrs_rdy = 0; zqcl_rdy = 0;
    reset_n = 0; #1;
    check_reset("async_reset_pins");
    model_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
